// File: rtl/flag_branch_ctrl_pkg.sv
// Shared constants for the flag register / branch-resolution stage:
// condition codes, flag bit positions and FSM state encoding.
package flag_branch_ctrl_pkg;

    localparam int unsigned FLAG_W = 3;
    localparam int unsigned CC_W   = 3;
    localparam int unsigned CNT_W  = 3;

    localparam int unsigned FLG_Z = 2;
    localparam int unsigned FLG_V = 1;
    localparam int unsigned FLG_N = 0;

    localparam logic [CC_W-1:0] CC_NE = 3'd0;
    localparam logic [CC_W-1:0] CC_EQ = 3'd1;
    localparam logic [CC_W-1:0] CC_GT = 3'd2;
    localparam logic [CC_W-1:0] CC_LT = 3'd3;
    localparam logic [CC_W-1:0] CC_GE = 3'd4;
    localparam logic [CC_W-1:0] CC_LE = 3'd5;
    localparam logic [CC_W-1:0] CC_OV = 3'd6;
    localparam logic [CC_W-1:0] CC_UN = 3'd7;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_REDIR  = 2'd1,
        ST_SQUASH = 2'd2
    } state_e;

endpackage

// File: rtl/flag_branch_ctrl_cond_eval.sv
// Combinational branch-condition evaluator over a {Z,V,N} flag vector.
module flag_branch_ctrl_cond_eval
    import flag_branch_ctrl_pkg::*;
(
    input  logic [CC_W-1:0]   cond,
    input  logic [FLAG_W-1:0] flags,
    output logic              take_c
);

    logic z;
    logic v;
    logic n;

    assign z = flags[FLG_Z];
    assign v = flags[FLG_V];
    assign n = flags[FLG_N];

    always_comb begin
        take_c = 1'b0;
        case (cond)
            CC_NE: take_c = ~z;
            CC_EQ: take_c = z;
            CC_GT: take_c = ~z & ~n;
            CC_LT: take_c = n;
            CC_GE: take_c = z | ~n;
            CC_LE: take_c = z | n;
            CC_OV: take_c = v;
            CC_UN: take_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/flag_branch_ctrl.sv
// Flag register and branch resolution behind the ALU: bypassed flag evaluation,
// one-cycle registered redirect, then a squash window for younger branches.
module flag_branch_ctrl
    import flag_branch_ctrl_pkg::*;
#(
    parameter int unsigned   PC_W       = 16,
    parameter int unsigned   SQUASH_CYC = 1,
    parameter logic [2:0]    FLAG_RST   = 3'b000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic            ex_stall,
    input  logic            ex_flush,
    input  logic [2:0]      flag_upd,
    input  logic            alu_z,
    input  logic            alu_v,
    input  logic            alu_n,
    input  logic            br_valid,
    input  logic [2:0]      br_cond,
    input  logic [PC_W-1:0] br_target,
    output logic [2:0]      flags_q,
    output logic            br_taken,
    output logic [PC_W-1:0] redirect_pc,
    output logic            squash_busy
);

    state_e              state_q;
    state_e              state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic                br_taken_d;
    logic [PC_W-1:0]     redirect_pc_d;
    logic                squash_busy_d;

    logic                upd_en;
    logic [FLAG_W-1:0]   upd_mask;
    logic [FLAG_W-1:0]   alu_flags;
    logic [FLAG_W-1:0]   flags_nx;
    logic                take;

    assign upd_en    = ex_valid & ~ex_stall & ~ex_flush;
    assign upd_mask  = {FLAG_W{upd_en}} & flag_upd;
    assign alu_flags = {alu_z, alu_v, alu_n};

    // Branch sees the flags written by the instruction sharing its EX slot.
    assign flags_nx = (flags_q & ~upd_mask) | (alu_flags & upd_mask);

    flag_branch_ctrl_cond_eval u_cond_eval (
        .cond   (br_cond),
        .flags  (flags_nx),
        .take_c (take)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        br_taken_d    = 1'b0;
        redirect_pc_d = redirect_pc;
        squash_busy_d = squash_busy;
        case (state_q)
            ST_RUN: begin
                if (br_valid && upd_en && take) begin
                    br_taken_d    = 1'b1;
                    redirect_pc_d = br_target;
                    state_d       = ST_REDIR;
                end
            end
            ST_REDIR: begin
                cnt_d         = CNT_W'(SQUASH_CYC - 1);
                squash_busy_d = 1'b1;
                state_d       = ST_SQUASH;
            end
            ST_SQUASH: begin
                if (!ex_stall) begin
                    if (cnt_q == '0) begin
                        squash_busy_d = 1'b0;
                        state_d       = ST_RUN;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            default: begin
                squash_busy_d = 1'b0;
                state_d       = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            flags_q     <= FLAG_RST;
            br_taken    <= 1'b0;
            redirect_pc <= '0;
            squash_busy <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            flags_q     <= flags_nx;
            br_taken    <= br_taken_d;
            redirect_pc <= redirect_pc_d;
            squash_busy <= squash_busy_d;
        end
    end

endmodule

// File: tb/tb_flag_branch_ctrl.sv
// Bench for flag_branch_ctrl: vector table, directed corner sequences and
// randomized traffic against a cycle-level reference model.
module tb_flag_branch_ctrl;

    localparam int unsigned PC_W = 16;
    localparam int unsigned SQ   = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            ex_valid;
    logic            ex_stall;
    logic            ex_flush;
    logic [2:0]      flag_upd;
    logic            alu_z;
    logic            alu_v;
    logic            alu_n;
    logic            br_valid;
    logic [2:0]      br_cond;
    logic [PC_W-1:0] br_target;
    logic [2:0]      flags_q;
    logic            br_taken;
    logic [PC_W-1:0] redirect_pc;
    logic            squash_busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    flag_branch_ctrl #(
        .PC_W       (PC_W),
        .SQUASH_CYC (SQ),
        .FLAG_RST   (3'b000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ex_valid    (ex_valid),
        .ex_stall    (ex_stall),
        .ex_flush    (ex_flush),
        .flag_upd    (flag_upd),
        .alu_z       (alu_z),
        .alu_v       (alu_v),
        .alu_n       (alu_n),
        .br_valid    (br_valid),
        .br_cond     (br_cond),
        .br_target   (br_target),
        .flags_q     (flags_q),
        .br_taken    (br_taken),
        .redirect_pc (redirect_pc),
        .squash_busy (squash_busy)
    );

    // Reference model: flags plus "cycles until branches are accepted again".
    logic [2:0]      m_flags = 3'b000;
    logic            m_taken = 1'b0;
    logic [PC_W-1:0] m_pc    = '0;
    logic            m_busy  = 1'b0;
    bit              m_redir = 1'b0;
    int              m_sq_left = 0;

    function automatic bit cond_true(input logic [2:0] c, input logic [2:0] f);
        bit z = f[2];
        bit v = f[1];
        bit n = f[0];
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || !n;
            3'd5: return z || n;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    task automatic model_step();
        bit         upd;
        logic [2:0] nx;
        logic [2:0] alu;
        if (rst) begin
            m_flags = 3'b000; m_taken = 1'b0; m_pc = '0; m_busy = 1'b0;
            m_redir = 1'b0;   m_sq_left = 0;
        end else begin
            upd = ex_valid && !ex_stall && !ex_flush;
            alu = {alu_z, alu_v, alu_n};
            nx  = m_flags;
            for (int i = 0; i < 3; i++)
                if (upd && flag_upd[i]) nx[i] = alu[i];
            if (m_redir) begin
                m_taken = 1'b0; m_redir = 1'b0; m_sq_left = SQ; m_busy = 1'b1;
            end else if (m_sq_left > 0) begin
                m_taken = 1'b0;
                if (!ex_stall) begin
                    m_sq_left = m_sq_left - 1;
                    if (m_sq_left == 0) m_busy = 1'b0;
                end
            end else if (br_valid && upd && cond_true(br_cond, nx)) begin
                m_taken = 1'b1; m_pc = br_target; m_redir = 1'b1;
            end else begin
                m_taken = 1'b0;
            end
            m_flags = nx;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: advance the model on the edge, then compare all outputs.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("model_flags",  32'(flags_q),     32'(m_flags));
        check("model_taken",  32'(br_taken),    32'(m_taken));
        check("model_pc",     32'(redirect_pc), 32'(m_pc));
        check("model_busy",   32'(squash_busy), 32'(m_busy));
    endtask

    task automatic drive(input logic v, input logic s, input logic f, input logic [2:0] u,
                         input logic z, input logic ov, input logic n, input logic bv,
                         input logic [2:0] c, input logic [PC_W-1:0] t);
        ex_valid = v; ex_stall = s; ex_flush = f; flag_upd = u;
        alu_z = z; alu_v = ov; alu_n = n; br_valid = bv; br_cond = c; br_target = t;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, '0);
    endtask

    typedef struct {
        logic       valid;
        logic       stall;
        logic       flush;
        logic [2:0] upd;
        logic       z;
        logic       v;
        logic       n;
        logic [2:0] cond;
        logic [2:0] exp_flags;
        logic       exp_taken;
    } vec_t;

    vec_t vecs[16];
    int   busy_cnt;

    initial begin
        // Each vector starts from reset flags 000 with br_valid=1.
        vecs[0]  = '{1, 0, 0, 3'b111, 1, 0, 0, 3'd1, 3'b100, 1};
        vecs[1]  = '{1, 0, 0, 3'b111, 0, 1, 0, 3'd6, 3'b010, 1};
        vecs[2]  = '{1, 0, 0, 3'b000, 0, 1, 0, 3'd6, 3'b000, 0};
        vecs[3]  = '{1, 0, 0, 3'b111, 0, 0, 1, 3'd3, 3'b001, 1};
        vecs[4]  = '{1, 0, 0, 3'b111, 0, 0, 0, 3'd2, 3'b000, 1};
        vecs[5]  = '{1, 0, 0, 3'b111, 0, 0, 1, 3'd2, 3'b001, 0};
        vecs[6]  = '{1, 0, 0, 3'b100, 1, 1, 1, 3'd0, 3'b100, 0};
        vecs[7]  = '{1, 0, 0, 3'b100, 1, 0, 0, 3'd4, 3'b100, 1};
        vecs[8]  = '{1, 0, 0, 3'b111, 0, 0, 1, 3'd4, 3'b001, 0};
        vecs[9]  = '{1, 0, 0, 3'b111, 0, 0, 1, 3'd5, 3'b001, 1};
        vecs[10] = '{1, 0, 0, 3'b000, 1, 1, 1, 3'd5, 3'b000, 0};
        vecs[11] = '{1, 0, 0, 3'b000, 0, 0, 0, 3'd7, 3'b000, 1};
        vecs[12] = '{1, 1, 0, 3'b111, 1, 0, 0, 3'd7, 3'b000, 0};
        vecs[13] = '{1, 0, 1, 3'b111, 1, 0, 0, 3'd7, 3'b000, 0};
        vecs[14] = '{0, 0, 0, 3'b111, 1, 0, 0, 3'd7, 3'b000, 0};
        vecs[15] = '{1, 0, 0, 3'b111, 1, 0, 0, 3'd0, 3'b100, 0};

        rst = 1'b1;
        idle();

        // Reset held two cycles, then released.
        tick(); tick();
        check("rst_flags", 32'(flags_q), 32'h0);
        check("rst_taken", 32'(br_taken), 32'h0);
        check("rst_busy",  32'(squash_busy), 32'h0);
        rst = 1'b0;
        tick();
        check("rel_flags", 32'(flags_q), 32'h0);
        check("rel_taken", 32'(br_taken), 32'h0);
        check("rel_busy",  32'(squash_busy), 32'h0);

        // Condition-code table, one reset-separated vector each.
        for (int i = 0; i < 16; i++) begin
            idle(); rst = 1'b1; tick(); rst = 1'b0;
            drive(vecs[i].valid, vecs[i].stall, vecs[i].flush, vecs[i].upd,
                  vecs[i].z, vecs[i].v, vecs[i].n, 1'b1, vecs[i].cond, PC_W'(16'h1000 + i));
            tick();
            check($sformatf("vec%0d_taken", i), 32'(br_taken), 32'(vecs[i].exp_taken));
            check($sformatf("vec%0d_flags", i), 32'(flags_q), 32'(vecs[i].exp_flags));
            if (vecs[i].exp_taken)
                check($sformatf("vec%0d_pc", i), 32'(redirect_pc), 32'h1000 + 32'(i));
        end

        // Bypass: SUB 5-5 sets Z in the same slot as a BEQ.
        idle(); rst = 1'b1; tick(); rst = 1'b0;
        drive(1, 0, 0, 3'b111, 1, 0, 0, 1, 3'd1, 16'h0040);
        tick();
        check("byp_taken", 32'(br_taken), 32'h1);
        check("byp_pc",    32'(redirect_pc), 32'h0040);
        check("byp_flags", 32'(flags_q), 32'h4);
        idle(); tick();
        check("byp_pulse_one", 32'(br_taken), 32'h0);

        // Squash window: three back-to-back younger branches are dropped.
        idle(); rst = 1'b1; tick(); rst = 1'b0;
        drive(1, 0, 0, 3'b000, 0, 0, 0, 1, 3'd7, 16'h0080);
        tick();
        check("sq_first", 32'(br_taken), 32'h1);
        drive(1, 0, 0, 3'b000, 0, 0, 0, 1, 3'd7, 16'h0088);
        busy_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("sq_drop%0d", k), 32'(br_taken), 32'h0);
            if (squash_busy) busy_cnt++;
        end
        check("sq_busy_cycles", 32'(busy_cnt), 32'd2);
        drive(1, 0, 0, 3'b000, 0, 0, 0, 1, 3'd7, 16'h0090);
        tick();
        check("sq_after_taken", 32'(br_taken), 32'h1);
        check("sq_after_pc",    32'(redirect_pc), 32'h0090);

        // Stall holds evaluation until it drops.
        idle(); rst = 1'b1; tick(); rst = 1'b0;
        drive(1, 1, 0, 3'b111, 0, 0, 0, 1, 3'd7, 16'h00a0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("stall%0d_taken", k), 32'(br_taken), 32'h0);
        end
        ex_stall = 1'b0;
        tick();
        check("stall_drop_taken", 32'(br_taken), 32'h1);
        check("stall_drop_pc",    32'(redirect_pc), 32'h00a0);
        idle();
        for (int k = 0; k < 4; k++) tick();
        drive(1, 0, 1, 3'b111, 1, 1, 1, 1, 3'd7, 16'h00b0);
        tick();
        check("flush_taken", 32'(br_taken), 32'h0);
        check("flush_flags", 32'(flags_q), 32'h0);

        // Reset mid-squash returns to RUN immediately.
        idle(); rst = 1'b1; tick(); rst = 1'b0;
        drive(1, 0, 0, 3'b000, 0, 0, 0, 1, 3'd7, 16'h00c0);
        tick();
        idle(); tick(); tick();
        check("midsq_busy", 32'(squash_busy), 32'h1);
        rst = 1'b1; tick(); rst = 1'b0;
        check("midsq_rst_busy",  32'(squash_busy), 32'h0);
        check("midsq_rst_taken", 32'(br_taken), 32'h0);
        drive(1, 0, 0, 3'b000, 0, 0, 0, 1, 3'd7, 16'h00d0);
        tick();
        check("midsq_next_taken", 32'(br_taken), 32'h1);
        check("midsq_next_pc",    32'(redirect_pc), 32'h00d0);

        // Randomized traffic against the model.
        for (int k = 0; k < 1500; k++) begin
            rst       = ($urandom_range(0, 63) == 0);
            ex_valid  = ($urandom_range(0, 3) != 0);
            ex_stall  = ($urandom_range(0, 3) == 0);
            ex_flush  = ($urandom_range(0, 7) == 0);
            flag_upd  = 3'($urandom_range(0, 7));
            alu_z     = 1'($urandom_range(0, 1));
            alu_v     = 1'($urandom_range(0, 1));
            alu_n     = 1'($urandom_range(0, 1));
            br_valid  = 1'($urandom_range(0, 1));
            br_cond   = 3'($urandom_range(0, 7));
            br_target = PC_W'($urandom);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
